// File: rtl/sel_pipe_stage_pkg.sv
// Shared MIPS datapath definitions used by the selector pipeline stage:
// word width and the select encodings of the PC-source and forwarding muxes.
package sel_pipe_stage_pkg;

    localparam int WORD_W = 32;

    // Number of sources behind each legacy datapath mux
    localparam int PCSRC_N = 3;
    localparam int FWD_N   = 3;

    // Next-PC source select: PC+4, branch target, jump target
    typedef enum logic [1:0] {
        PCSRC_PC4 = 2'd0,
        PCSRC_BR  = 2'd1,
        PCSRC_JMP = 2'd2
    } pcsrc_e;

    // Operand forwarding select: register file, EX/MEM result, MEM/WB result
    typedef enum logic [1:0] {
        FWD_REG   = 2'd0,
        FWD_EXMEM = 2'd1,
        FWD_MEMWB = 2'd2
    } fwd_e;

endpackage

// File: rtl/sel_pipe_stage_muxn.sv
// Combinational N:1 selector with binary select. Select codes that do not
// name an input (only possible when NUM_IN is not a power of 2) fall back to
// input 0. The legacy 2:1/3:1/4:1 datapath muxes are instances of this block.
module sel_pipe_stage_muxn #(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 4,
    parameter int SEL_W  = $clog2(NUM_IN)
) (
    input  logic [NUM_IN*WIDTH-1:0] din_i,
    input  logic [SEL_W-1:0]        sel_i,
    output logic [WIDTH-1:0]        dout_o
);

    localparam int NUM_LANES = 2 ** SEL_W;

    // One lane per select code; unused codes alias input 0
    logic [WIDTH-1:0] lane_s [NUM_LANES];

    for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
        if (k < NUM_IN) begin : g_real
            assign lane_s[k] = din_i[k*WIDTH +: WIDTH];
        end else begin : g_alias
            assign lane_s[k] = din_i[WIDTH-1:0];
        end
    end

    assign dout_o = lane_s[sel_i];

endmodule

// File: rtl/sel_pipe_stage.sv
// N:1 operand / next-PC selector fused with one pipeline register and a
// valid/ready handshake. Single entry with pass-through ready, so full
// throughput is one beat per cycle. Flush loads RST_VAL and drops the entry.
// Optional feature: define SELPIPE_ERR_EN to get a sticky sel_err flag that
// records any accepted beat whose select names no input; otherwise sel_err
// is tied low and no compare logic exists.
module sel_pipe_stage
    import sel_pipe_stage_pkg::*;
#(
    parameter int               WIDTH   = WORD_W,
    parameter int               NUM_IN  = 4,
    parameter logic [WIDTH-1:0] RST_VAL = '0,
    localparam int              SEL_W   = $clog2(NUM_IN)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_IN*WIDTH-1:0] din,
    input  logic [SEL_W-1:0]        sel,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    flush,
    output logic [WIDTH-1:0]        dout,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    sel_err
);

    logic [WIDTH-1:0] mux_s;
    logic [WIDTH-1:0] dout_q;
    logic [WIDTH-1:0] dout_d;
    logic             valid_q;
    logic             valid_d;
    logic             accept_s;

    // Selection happens ahead of the register only; dout is always a flop
    sel_pipe_stage_muxn #(
        .WIDTH  (WIDTH),
        .NUM_IN (NUM_IN),
        .SEL_W  (SEL_W)
    ) u_muxn (
        .din_i  (din),
        .sel_i  (sel),
        .dout_o (mux_s)
    );

    // Space is free when empty or when the held entry leaves this cycle
    assign in_ready = ~valid_q | out_ready;
    assign accept_s = in_valid & in_ready;

    // Next-state: flush beats accept, accept beats consume, otherwise hold
    always_comb begin
        dout_d  = dout_q;
        valid_d = valid_q;
        if (flush) begin
            dout_d  = RST_VAL;
            valid_d = 1'b0;
        end else if (accept_s) begin
            dout_d  = mux_s;
            valid_d = 1'b1;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end else begin
            dout_d  = dout_q;
            valid_d = valid_q;
        end
    end

    // Pipeline register and valid flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_q  <= RST_VAL;
            valid_q <= 1'b0;
        end else begin
            dout_q  <= dout_d;
            valid_q <= valid_d;
        end
    end

    assign dout      = dout_q;
    assign out_valid = valid_q;

`ifdef SELPIPE_ERR_EN
    localparam logic [SEL_W:0] NUM_IN_C = (SEL_W+1)'(NUM_IN);

    logic err_q;
    logic err_d;
    logic illegal_s;

    assign illegal_s = ({1'b0, sel} >= NUM_IN_C);

    // Sticky: only reset clears it, flush leaves it alone
    always_comb begin
        err_d = err_q | (accept_s & illegal_s);
    end

    // Illegal-select flag register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign sel_err = err_q;
`else
    assign sel_err = 1'b0;
`endif

endmodule

// File: tb/tb_sel_pipe_stage.sv
// Directed bench for sel_pipe_stage: a 4-input 32-bit instance driven from a
// vector table, plus a 3-input 8-bit instance for illegal select and a
// non-zero reset/flush value.
module tb_sel_pipe_stage;

    localparam int W = 32;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    // Instance A: NUM_IN=4, WIDTH=32, RST_VAL=0
    logic [4*W-1:0] a_din;
    logic [1:0]     a_sel;
    logic           a_in_valid, a_in_ready, a_flush, a_out_valid, a_out_ready, a_sel_err;
    logic [W-1:0]   a_dout;

    sel_pipe_stage #(.WIDTH(W), .NUM_IN(4), .RST_VAL(32'h0)) dut_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .din       (a_din),
        .sel       (a_sel),
        .in_valid  (a_in_valid),
        .in_ready  (a_in_ready),
        .flush     (a_flush),
        .dout      (a_dout),
        .out_valid (a_out_valid),
        .out_ready (a_out_ready),
        .sel_err   (a_sel_err)
    );

    // Instance B: NUM_IN=3, WIDTH=8, RST_VAL=0x5A
    logic [3*8-1:0] b_din;
    logic [1:0]     b_sel;
    logic           b_in_valid, b_in_ready, b_flush, b_out_valid, b_out_ready, b_sel_err;
    logic [7:0]     b_dout;

    sel_pipe_stage #(.WIDTH(8), .NUM_IN(3), .RST_VAL(8'h5A)) dut_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .din       (b_din),
        .sel       (b_sel),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .flush     (b_flush),
        .dout      (b_dout),
        .out_valid (b_out_valid),
        .out_ready (b_out_ready),
        .sel_err   (b_sel_err)
    );

`ifdef SELPIPE_ERR_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    typedef struct {
        logic [4*W-1:0] din;
        logic [1:0]     sel;
        logic           in_valid;
        logic           out_ready;
        logic           flush;
        logic           exp_ready;
        logic [W-1:0]   exp_dout;
        logic           exp_valid;
    } vec_t;

    localparam int NV = 20;
    vec_t vecs [NV];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // input 0 is a, input 3 is d
    function automatic logic [4*W-1:0] pack4(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic [W-1:0] c, input logic [W-1:0] d);
        return {d, c, b, a};
    endfunction

    function automatic vec_t mk(input logic [4*W-1:0] din, input logic [1:0] sel,
                                input logic iv, input logic ordy, input logic fl,
                                input logic erdy, input logic [W-1:0] edout, input logic evld);
        vec_t v;
        v.din = din; v.sel = sel; v.in_valid = iv; v.out_ready = ordy; v.flush = fl;
        v.exp_ready = erdy; v.exp_dout = edout; v.exp_valid = evld;
        return v;
    endfunction

    initial begin
        logic [4*W-1:0] base;
        base = pack4(32'hA, 32'hB, 32'hC, 32'hD);

        // select, then a 3-cycle stall with changing din, then release
        vecs[0] = mk(base, 2'd2, 1'b1, 1'b1, 1'b0, 1'b1, 32'hC, 1'b1);
        vecs[1] = mk(pack4(32'h1A, 32'h1B, 32'h1C, 32'h1D), 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 32'hC, 1'b1);
        vecs[2] = mk(pack4(32'h2A, 32'h2B, 32'h2C, 32'h2D), 2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 32'hC, 1'b1);
        vecs[3] = mk(pack4(32'h3A, 32'h3B, 32'h3C, 32'h3D), 2'd3, 1'b1, 1'b0, 1'b0, 1'b0, 32'hC, 1'b1);
        vecs[4] = mk(pack4(32'h4A, 32'h4B, 32'h4C, 32'h4D), 2'd3, 1'b1, 1'b1, 1'b0, 1'b1, 32'h4D, 1'b1);
        // 8 back-to-back beats, sel cycling 0..3; input j of beat k is 0x50+4k+j
        for (int k = 0; k < 8; k++) begin
            logic [W-1:0] b0;
            b0 = 32'h50 + 32'(4 * k);
            vecs[5+k] = mk(pack4(b0, b0 + 32'd1, b0 + 32'd2, b0 + 32'd3), 2'(k % 4),
                           1'b1, 1'b1, 1'b0, 1'b1, b0 + 32'(k % 4), 1'b1);
        end
        // consume without accept: valid drops, data kept (last beat 0x6F)
        vecs[13] = mk(base, 2'd1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h6F, 1'b0);
        vecs[14] = mk(base, 2'd1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h6F, 1'b0);
        // load while empty with out_ready low
        vecs[15] = mk(base, 2'd0, 1'b1, 1'b0, 1'b0, 1'b1, 32'hA, 1'b1);
        // flush during stall with a beat offered
        vecs[16] = mk(base, 2'd1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        vecs[17] = mk(base, 2'd1, 1'b1, 1'b1, 1'b0, 1'b1, 32'hB, 1'b1);
        // flush while a beat is actually accepted: the beat is lost
        vecs[18] = mk(base, 2'd2, 1'b1, 1'b1, 1'b1, 1'b1, 32'h0, 1'b0);
        vecs[19] = mk(base, 2'd1, 1'b1, 1'b0, 1'b0, 1'b1, 32'hB, 1'b1);

        rst_n = 1'b0;
        a_din = '0; a_sel = 2'd0; a_in_valid = 1'b0; a_flush = 1'b0; a_out_ready = 1'b0;
        b_din = '0; b_sel = 2'd0; b_in_valid = 1'b0; b_flush = 1'b0; b_out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_a_dout", a_dout, 32'h0);
        chk("rst_a_valid", 32'(a_out_valid), 32'h0);
        chk("rst_a_ready", 32'(a_in_ready), 32'h1);
        chk("rst_b_dout", 32'(b_dout), 32'h5A);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            a_din = vecs[i].din; a_sel = vecs[i].sel; a_in_valid = vecs[i].in_valid;
            a_out_ready = vecs[i].out_ready; a_flush = vecs[i].flush;
            #1;
            chk($sformatf("v%0d_in_ready", i), 32'(a_in_ready), 32'(vecs[i].exp_ready));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_dout", i), a_dout, vecs[i].exp_dout);
            chk($sformatf("v%0d_out_valid", i), 32'(a_out_valid), 32'(vecs[i].exp_valid));
        end
        chk("a_sel_err", 32'(a_sel_err), 32'h0);

        // async reset mid-stall: takes effect without a clock edge
        a_in_valid = 1'b0; a_out_ready = 1'b0;
        #1;
        chk("pre_rst_valid", 32'(a_out_valid), 32'h1);
        chk("pre_rst_ready", 32'(a_in_ready), 32'h0);
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_rst_dout", a_dout, 32'h0);
        chk("async_rst_valid", 32'(a_out_valid), 32'h0);
        chk("async_rst_ready", 32'(a_in_ready), 32'h1);
        @(negedge clk);
        rst_n = 1'b1;

        // instance B: legal select, illegal select, then flush
        b_din = {8'h33, 8'h22, 8'h11};
        b_out_ready = 1'b1;
        b_in_valid = 1'b1;
        b_sel = 2'd2;
        @(posedge clk); #1;
        chk("b_legal_dout", 32'(b_dout), 32'h33);
        chk("b_legal_err", 32'(b_sel_err), 32'h0);
        b_sel = 2'd3;
        @(posedge clk); #1;
        chk("b_illegal_dout", 32'(b_dout), 32'h11);
        chk("b_illegal_valid", 32'(b_out_valid), 32'h1);
        chk("b_illegal_err", 32'(b_sel_err), 32'(EXP_ERR));
        b_sel = 2'd1;
        b_flush = 1'b1;
        @(posedge clk); #1;
        chk("b_flush_dout", 32'(b_dout), 32'h5A);
        chk("b_flush_valid", 32'(b_out_valid), 32'h0);
        chk("b_flush_err", 32'(b_sel_err), 32'(EXP_ERR));
        b_flush = 1'b0;
        b_in_valid = 1'b0;
        @(posedge clk); #1;
        chk("b_err_hold", 32'(b_sel_err), 32'(EXP_ERR));
        chk("b_idle_dout", 32'(b_dout), 32'h5A);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
